up_counter_ctrl: RTL and testbench

- Loadable up-counter with a start/stop control FSM. It is the count-up counterpart to the block-level 4-bit down counter.
- Counts from 0 toward a programmable limit.
- Flags terminal count, and either wraps (free-run) or stops (one-shot).
- Used as an event/interval timer alongside the down counter in the counter library; supports cascading via tc.

---
 rtl/up_counter_ctrl_pkg.sv | 13 +
 rtl/up_counter_ctrl_if.sv | 33 +++
 rtl/up_counter_ctrl.sv | 100 ++++++++++
 tb/tb_up_counter_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_counter_ctrl_pkg.sv
// Shared state and mode encodings for the loadable up-counter control block.
package up_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/up_counter_ctrl_if.sv
// Control/status bundle of the up-counter; the slave side is the counter itself.
interface up_counter_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             start_i;
  logic             stop_i;
  logic             en_i;
  logic             mode_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic             limit_sel_i;
  logic [WIDTH-1:0] limit_i;
  logic             clr_ovf_i;
  logic [WIDTH-1:0] out_o;
  logic             tc_o;
  logic             busy_o;
  logic             done_o;
  logic             ovf_o;

  modport master (
    output start_i, stop_i, en_i, mode_i, load_i, load_val_i,
           limit_sel_i, limit_i, clr_ovf_i,
    input  out_o, tc_o, busy_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, stop_i, en_i, mode_i, load_i, load_val_i,
           limit_sel_i, limit_i, clr_ovf_i,
    output out_o, tc_o, busy_o, done_o, ovf_o
  );

endinterface

// File: rtl/up_counter_ctrl.sv
// Loadable up-counter with start/stop FSM, terminal-count pulse, one-shot
// completion flag and a sticky wrap flag for free-run operation.
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  up_counter_ctrl_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [WIDTH-1:0] effLimit;
  logic             termHit;

  // Limit is followed live; >= stops a loaded value above it from running away.
  assign effLimit = bus.limit_sel_i ? bus.limit_i : DEFAULT_LIMIT;
  assign termHit  = (count_q >= effLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
      if (bus.load_i) begin
        count_q <= bus.load_val_i;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start_i) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              count_q <= '0;
            end
          end
          RUN: begin
            if (bus.stop_i) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (bus.en_i) begin
              if (termHit) begin
                tc_q <= 1'b1;
                // A wrap sets ovf after the clear above, so set wins.
                case (bus.mode_i)
                  MODE_FREE: begin
                    count_q <= '0;
                    ovf_q   <= 1'b1;
                  end
                  MODE_ONESHOT: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                endcase
              end else begin
                count_q <= count_q + 1'b1;
              end
            end
          end
          DONE: begin
            if (bus.start_i) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              count_q <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_o  = count_q;
  assign bus.tc_o   = tc_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed self-checking bench for up_counter_ctrl; each compare packs
// {out, tc, busy, done, ovf} against a hand-computed expectation.
module tb_up_counter_ctrl;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  up_counter_ctrl_if #(.WIDTH(4)) bus();

  up_counter_ctrl #(
    .WIDTH(4),
    .DEFAULT_LIMIT(4'b1111)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] snap();
    return {bus.out_o, bus.tc_o, bus.busy_o, bus.done_o, bus.ovf_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    exp = 8'h00;
    #3;
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL reset_async got=%b exp=%b", snap(), exp);
    end
    step();
    step();
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL reset_held got=%b exp=%b", snap(), exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [7:0] exp;
    bus.limit_sel_i = 1'b0;
    bus.mode_i      = 1'b0;
    bus.en_i        = 1'b1;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL free_start got=%b exp=%b", snap(), exp);
    end
    for (int i = 1; i <= 15; i++) begin
      step();
      exp = {4'(i), 1'b0, 1'b1, 1'b0, 1'b0};
      vecCount++;
      if (snap() !== exp) begin
        missCount++;
        $display("[TB] FAIL free_count%0d got=%b exp=%b", i, snap(), exp);
      end
    end
    step();
    exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL free_wrap got=%b exp=%b", snap(), exp);
    end
    step();
    exp = {4'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL free_after_wrap got=%b exp=%b", snap(), exp);
    end
    bus.stop_i    = 1'b1;
    bus.clr_ovf_i = 1'b1;
    step();
    bus.stop_i    = 1'b0;
    bus.clr_ovf_i = 1'b0;
    exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL free_stop_clr got=%b exp=%b", snap(), exp);
    end
  endtask

  task automatic test_one_shot();
    logic [7:0] exp;
    bus.limit_sel_i = 1'b1;
    bus.limit_i     = 4'd5;
    bus.mode_i      = 1'b1;
    bus.en_i        = 1'b1;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = {4'(i), 1'b0, 1'b1, 1'b0, 1'b0};
      vecCount++;
      if (snap() !== exp) begin
        missCount++;
        $display("[TB] FAIL oneshot_count%0d got=%b exp=%b", i, snap(), exp);
      end
    end
    step();
    exp = {4'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL oneshot_term got=%b exp=%b", snap(), exp);
    end
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
    exp = {4'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL oneshot_hold got=%b exp=%b", snap(), exp);
    end
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL oneshot_restart got=%b exp=%b", snap(), exp);
    end
  endtask

  task automatic test_enable_stop();
    logic [7:0] exp;
    logic [3:0] expOut [5] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
    bus.limit_i = 4'd3;
    bus.mode_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.en_i = (i % 2 == 1);
      step();
      exp = {expOut[i], 1'b0, 1'b1, 1'b0, 1'b0};
      vecCount++;
      if (snap() !== exp) begin
        missCount++;
        $display("[TB] FAIL enable_gate%0d got=%b exp=%b", i, snap(), exp);
      end
    end
    bus.en_i   = 1'b1;
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
    exp = {4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL stop_hold got=%b exp=%b", snap(), exp);
    end
  endtask

  task automatic test_load_above();
    logic [7:0] exp;
    bus.limit_i = 4'd4;
    bus.mode_i  = 1'b0;
    bus.en_i    = 1'b1;
    bus.start_i = 1'b1;
    step();
    step();
    bus.start_i = 1'b0;
    exp = {4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL start_ignored_run got=%b exp=%b", snap(), exp);
    end
    bus.load_i     = 1'b1;
    bus.load_val_i = 4'd9;
    step();
    bus.load_i = 1'b0;
    exp = {4'd9, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL load_value got=%b exp=%b", snap(), exp);
    end
    step();
    exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL load_above_free got=%b exp=%b", snap(), exp);
    end
    bus.load_i = 1'b1;
    step();
    bus.load_i = 1'b0;
    bus.mode_i = 1'b1;
    step();
    exp = {4'd9, 1'b1, 1'b0, 1'b1, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL load_above_oneshot got=%b exp=%b", snap(), exp);
    end
  endtask

  task automatic test_limit_zero_ovf();
    logic [7:0] exp;
    bus.clr_ovf_i = 1'b1;
    step();
    bus.clr_ovf_i = 1'b0;
    exp = {4'd9, 1'b0, 1'b0, 1'b1, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL clr_ovf_nowrap got=%b exp=%b", snap(), exp);
    end
    bus.limit_i = 4'd0;
    bus.mode_i  = 1'b0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecCount++;
      if (snap() !== exp) begin
        missCount++;
        $display("[TB] FAIL limit0_tc%0d got=%b exp=%b", i, snap(), exp);
      end
    end
    bus.clr_ovf_i = 1'b1;
    step();
    exp = {4'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL clr_on_wrap got=%b exp=%b", snap(), exp);
    end
    bus.en_i = 1'b0;
    step();
    bus.clr_ovf_i = 1'b0;
    exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL clr_no_wrap got=%b exp=%b", snap(), exp);
    end
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    bus.limit_i = 4'd0;
    bus.en_i    = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    bus.limit_sel_i = 1'b0;
    repeat (7) step();
    exp = {4'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL pre_reset got=%b exp=%b", snap(), exp);
    end
    #3;
    rst_n = 1'b0;
    #1;
    exp = 8'h00;
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL async_reset got=%b exp=%b", snap(), exp);
    end
    step();
    rst_n       = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    exp = {4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecCount++;
    if (snap() !== exp) begin
      missCount++;
      $display("[TB] FAIL restart_after_reset got=%b exp=%b", snap(), exp);
    end
  endtask

  initial begin
    vecCount        = 0;
    missCount       = 0;
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.en_i        = 1'b0;
    bus.mode_i      = 1'b0;
    bus.load_i      = 1'b0;
    bus.load_val_i  = 4'd0;
    bus.limit_sel_i = 1'b0;
    bus.limit_i     = 4'd0;
    bus.clr_ovf_i   = 1'b0;
    test_reset();
    test_free_run();
    test_one_shot();
    test_enable_stop();
    test_load_above();
    test_limit_zero_ovf();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
